// File: rtl/dataflow_decoder_if.sv
// Stream and statistics bundle for dataflow_decoder.
// slave: decoder view; master: producer/consumer/monitor view.
interface dataflow_decoder_if #(
  parameter int ACC_W = 16,
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_count;
  logic             out_err;
  logic             acc_clear;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] word_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             err_sticky;

  modport slave (
    input  in_valid, in_code, out_ready, acc_clear,
    output in_ready, out_valid, out_count, out_err,
           acc_sum, word_cnt, err_cnt, err_sticky
  );

  modport master (
    output in_valid, in_code, out_ready, acc_clear,
    input  in_ready, out_valid, out_count, out_err,
           acc_sum, word_cnt, err_cnt, err_sticky
  );
endinterface

// File: rtl/dataflow_decoder.sv
// Dataflow code word decoder: input FIFO, consistency check, popcount
// decode into a one-entry output register, running statistics.
module dataflow_decoder #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 16,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dataflow_decoder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  // FIFO storage; pointers carry an extra wrap bit to tell full from empty
  logic [4:0]       r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_empty, w_full, w_push, w_pop;
  logic [4:0]       w_head;

  state_t           r_state, w_state_nxt;
  logic             w_load, w_hs;

  logic             w_o0, w_o1, w_o2h, w_o2l, w_o3;
  logic [1:0]       w_ab, w_cd;
  logic             w_err;
  logic [2:0]       w_count;

  logic [2:0]       r_count;
  logic             r_err;
  logic [ACC_W-1:0] r_acc_sum, r_word_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_err_sticky;
  logic [ACC_W:0]   w_sum_ext;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // No bypass: a full FIFO refuses even when the head pops this cycle
  assign bus.in_ready = ~w_full;
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = w_load;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // FIFO data write; storage needs no reset since pointers gate it
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.in_code;
  end

  // FIFO pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state, load and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          w_hs = 1'b1;
          if (!w_empty) w_load      = 1'b1;
          else          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Consistency check and popcount of the FIFO head
  always_comb begin
    w_o0  = w_head[4];
    w_o1  = w_head[3];
    w_o2h = w_head[2];
    w_o2l = w_head[1];
    w_o3  = w_head[0];
    w_ab  = w_o2h ? 2'd2 : (w_o2l ? 2'd1 : 2'd0);
    w_cd  = w_o1  ? 2'd2 : (w_o0  ? 2'd1 : 2'd0);
    w_err = (w_o1 & ~w_o0) | (w_o2h & ~w_o2l) |
            (w_o3 != (w_o2l & ~w_o2h & w_o0));
    w_count = w_err ? 3'd0 : ({1'b0, w_ab} + {1'b0, w_cd});
  end

  // Output register load; held until the next handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_count <= w_count;
      r_err   <= w_err;
    end
  end

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_count = r_count;
  assign bus.out_err   = r_err;

  assign w_sum_ext = {1'b0, r_acc_sum} + {{(ACC_W-2){1'b0}}, r_count};

  // Statistics on delivered words; clear wins over a coincident handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_sum    <= '0;
      r_word_cnt   <= '0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (bus.acc_clear) begin
      r_acc_sum    <= '0;
      r_word_cnt   <= '0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_hs) begin
      r_word_cnt <= r_word_cnt + ACC_W'(1);
      if (r_err) begin
        r_err_sticky <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
      end else begin
        r_acc_sum <= w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
      end
    end
  end

  assign bus.acc_sum    = r_acc_sum;
  assign bus.word_cnt   = r_word_cnt;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.err_sticky = r_err_sticky;
endmodule

// File: tb/tb_dataflow_decoder.sv
// Directed bench for dataflow_decoder (ACC_W=4 to reach saturation).
module tb_dataflow_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dataflow_decoder_if #(.ACC_W(4), .ERR_W(8)) ifc ();

  dataflow_decoder #(.DEPTH(4), .ACC_W(4), .ERR_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag, input int sum, input int wc,
                           input int ec, input int st);
    chk({tag, ".acc_sum"},    32'(ifc.acc_sum),    32'(sum));
    chk({tag, ".word_cnt"},   32'(ifc.word_cnt),   32'(wc));
    chk({tag, ".err_cnt"},    32'(ifc.err_cnt),    32'(ec));
    chk({tag, ".err_sticky"}, 32'(ifc.err_sticky), 32'(st));
  endtask

  task automatic chk_out(input string tag, input int cnt, input int err);
    chk({tag, ".out_valid"}, 32'(ifc.out_valid), 32'd1);
    chk({tag, ".out_count"}, 32'(ifc.out_count), 32'(cnt));
    chk({tag, ".out_err"},   32'(ifc.out_err),   32'(err));
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_code   = 5'b0;
    ifc.out_ready = 1'b0;
    ifc.acc_clear = 1'b0;

    // Reset state
    #12;
    chk("rst.in_ready",  32'(ifc.in_ready),  32'd1);
    chk("rst.out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst.out_count", 32'(ifc.out_count), 32'd0);
    chk_stats("rst", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    chk("idle.in_ready",  32'(ifc.in_ready),  32'd1);
    chk("idle.out_valid", 32'(ifc.out_valid), 32'd0);

    // Valid words back-to-back
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_code   = 5'b00000;
    tick();
    chk("lat.out_valid", 32'(ifc.out_valid), 32'd0);
    ifc.in_code = 5'b11011;
    tick();
    chk_out("w0", 0, 0);
    ifc.in_code = 5'b11110;
    tick();
    chk_out("w1", 3, 0);
    chk("w1.word_cnt", 32'(ifc.word_cnt), 32'd1);
    ifc.in_valid = 1'b0;
    tick();
    chk_out("w2", 4, 0);
    chk("w2.acc_sum", 32'(ifc.acc_sum), 32'd3);
    tick();
    chk("ok.out_valid", 32'(ifc.out_valid), 32'd0);
    chk_stats("ok", 7, 3, 0, 0);

    // Inconsistent words
    ifc.in_valid = 1'b1;
    ifc.in_code  = 5'b01000;
    tick();
    ifc.in_code = 5'b00100;
    tick();
    chk_out("e0", 0, 1);
    ifc.in_code = 5'b10001;
    tick();
    chk_out("e1", 0, 1);
    ifc.in_valid = 1'b0;
    tick();
    chk_out("e2", 0, 1);
    tick();
    chk("err.out_valid", 32'(ifc.out_valid), 32'd0);
    chk_stats("err", 7, 6, 3, 1);

    // Clear with output idle
    ifc.acc_clear = 1'b1;
    tick();
    ifc.acc_clear = 1'b0;
    chk_stats("clr", 0, 0, 0, 0);

    // Backpressure: 5 words fill output register plus 4-deep FIFO
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_code = 5'b00000; tick();
    ifc.in_code = 5'b10000; tick();
    ifc.in_code = 5'b10011; tick();
    ifc.in_code = 5'b11011; tick();
    ifc.in_code = 5'b11110; tick();
    chk("full.in_ready", 32'(ifc.in_ready), 32'd0);
    chk_out("full.hold", 0, 0);
    ifc.in_code = 5'b01000;          // 6th word must be refused
    tick();
    chk("full6.in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    tick(); chk_out("drain1", 1, 0);
    tick(); chk_out("drain2", 2, 0);
    tick(); chk_out("drain3", 3, 0);
    tick(); chk_out("drain4", 4, 0);
    tick();
    chk("drain.out_valid", 32'(ifc.out_valid), 32'd0);
    chk_stats("drain", 10, 5, 0, 0);

    // Saturating acc_sum with five 11110 words
    ifc.acc_clear = 1'b1;
    tick();
    ifc.acc_clear = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_code   = 5'b11110;
    tick(); tick();
    tick(); chk_stats("sat1", 4, 1, 0, 0);
    tick(); chk_stats("sat2", 8, 2, 0, 0);
    tick(); chk_stats("sat3", 12, 3, 0, 0);
    ifc.in_valid = 1'b0;
    tick(); chk_stats("sat4", 15, 4, 0, 0);
    tick(); chk_stats("sat5", 15, 5, 0, 0);
    chk("sat.out_valid", 32'(ifc.out_valid), 32'd0);

    // Clear coincident with a handshake
    ifc.in_valid = 1'b1;
    ifc.in_code  = 5'b01000;
    tick();
    ifc.in_code = 5'b11110;
    tick();
    ifc.in_valid = 1'b0;
    tick();
    chk_out("cc.load", 4, 0);
    chk_stats("cc.pre", 15, 6, 1, 1);
    ifc.acc_clear = 1'b1;
    tick();
    ifc.acc_clear = 1'b0;
    chk("cc.out_valid", 32'(ifc.out_valid), 32'd0);
    chk_stats("cc.post", 0, 0, 0, 0);

    // Async reset while holding a word, with one more buffered
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_code   = 5'b10000;
    tick(); tick();
    ifc.in_valid = 1'b0;
    tick();
    chk("ar.pre_valid", 32'(ifc.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(ifc.out_valid), 32'd0);
    chk("ar.in_ready",  32'(ifc.in_ready),  32'd1);
    @(negedge clk) rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    tick(); tick();
    chk("ar.discard", 32'(ifc.out_valid), 32'd0);
    chk_stats("ar", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dataflow_decoder.md
Name: dataflow_decoder

Overview:
Receiving end of the 5-bit dataflow code word {o0, o1, o2[1], o2[0], o3}, where:
- o0 = i2|i3, o1 = i2&i3
- o2[1] = i0&i1, o2[0] = i0|i1
- o3 = (i0^i1)&(o0|o1)

The block buffers incoming words behind a valid/ready handshake, checks each word for consistency, and decodes the population count of the original i0..i3 (0..4). It keeps running statistics: count sum, word count, error count and a sticky error flag. It sits downstream of the combinational encoder and feeds a consumer over a second valid/ready interface.

Parameters:
- DEPTH, 4, input FIFO entries (power of two, >=2)
- ACC_W, 16, width of acc_sum and word_cnt
- ERR_W, 8, width of err_cnt

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  code word present
- in_ready  out  1  FIFO can accept (= !full)
- in_code  in  5  [4]=o0 [3]=o1 [2]=o2[1] [1]=o2[0] [0]=o3
- out_valid  out  1  decoded result held in output register
- out_ready  in  1  consumer accepts
- out_count  out  3  population count 0..4 (0 when out_err)
- out_err  out  1  word failed consistency check
- acc_clear  in  1  synchronous clear of statistics
- acc_sum  out  ACC_W  saturating sum of valid counts
- word_cnt  out  ACC_W  wrapping count of delivered words
- err_cnt  out  ERR_W  saturating count of error words
- err_sticky  out  1  set on any delivered error word

Behaviour:
- Reset (rst_n=0, async):
  - FIFO pointers cleared.
  - Output register EMPTY: out_valid=0, out_count=0, out_err=0.
  - acc_sum=0, word_cnt=0, err_cnt=0, err_sticky=0.
  - in_ready=1, since the FIFO is empty.
  - Reset mid-operation discards all buffered words.
- Input: push on in_valid&in_ready. in_ready is combinational !full with no bypass, so a full FIFO never accepts, even if a pop occurs in the same cycle. Push and pop in the same cycle are allowed when not full.
- Output register, two states:
  - EMPTY -> FULL when FIFO is non-empty (pop and decode at that edge).
  - FULL -> EMPTY on out_valid&out_ready with FIFO empty.
  - FULL -> FULL (reload) on handshake with FIFO non-empty. This sustains one word per cycle.
  - out_valid=1 iff FULL. Held values are stable until the handshake.
- Latency: a word pushed at edge N into an empty FIFO with output EMPTY has out_valid=1 after edge N+1.
- Decode (registered on load):
  - ab = o2[1] ? 2 : (o2[0] ? 1 : 0)
  - cd = o1 ? 2 : (o0 ? 1 : 0)
  - count = ab + cd
- Error when any of the following holds; on error, out_count=0 and out_err=1:
  - o1 & ~o0
  - o2[1] & ~o2[0]
  - o3 != (o2[0] & ~o2[1] & o0)
- Statistics update only on output handshake:
  - word_cnt += 1, wrapping.
  - If !out_err: acc_sum += out_count, saturating at 2^ACC_W-1.
  - If out_err: err_cnt += 1 (saturating at 2^ERR_W-1) and err_sticky <= 1.
- acc_clear: zeroes acc_sum, word_cnt, err_cnt and err_sticky next edge.
  - Takes precedence over a coincident handshake. That word is still delivered but not counted.
  - Does not touch the FIFO or the output register.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, all statistics 0. Assert rst_n low while out_valid=1 -> out_valid drops immediately (async).
- Words 00000, 11011, 11110 with out_ready=1:
  - out_count 0, 3, 4 respectively, out_err=0.
  - Back-to-back at one per cycle after the first, with first-word latency 1 edge.
  - Final acc_sum=7, word_cnt=3.
- Errors 01000, 00100, 10001:
  - Each gives out_err=1 and out_count=0.
  - err_cnt=3, err_sticky=1, acc_sum unchanged.
- out_ready=0, push 5 words with DEPTH=4:
  - One word loads into the output register, 4 remain in the FIFO, in_ready=0.
  - A 6th in_valid is not accepted.
  - Release out_ready -> all 5 words delivered in order, none lost or duplicated.
- ACC_W=4, feed five 11110 words -> acc_sum sequence 4, 8, 12, 15, 15; word_cnt 1..5.
- acc_clear asserted on the same cycle as the handshake of 11110 -> word delivered, next-cycle acc_sum=0, word_cnt=0, err_sticky=0.
